// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: the controller is the master, the ALU the slave.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle ADD/SUB/AND/ORR/EOR, iterative shift-add MUL, optional restoring DIV.
// Define ALU_MC_DIV_EN to build the unsigned divider for op 110; otherwise op 110 is illegal.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;    // MUL: multiplicand, DIV: divisor
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] fin_res;
  logic [3:0]       fin_flg;
`ifdef ALU_MC_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   div_tmp;
  logic [WIDTH:0]   div_diff;
`endif

  function automatic logic is_iter(input logic [2:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

  // Single-cycle ops and illegal-op encoding; returns {N,Z,C,V,result}.
  function automatic logic [WIDTH+3:0] alu_basic(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    sum = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + (WIDTH+1)'(op[0]);
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_ORR:  r = a | b;
      OP_EOR:  r = a ^ b;
      default: return {4'b0101, {WIDTH{1'b0}}};
    endcase
    return {r[WIDTH-1], (r == '0), c, v, r};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = is_iter(bus.op) ? ITER : DONE;
      ITER:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One radix-2 step: MUL adds then shifts right, DIV shifts left then trial-subtracts.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    hi_d    = mul_sum[WIDTH:1];
    lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
    fin_res = lo_d;
    fin_flg = {lo_d[WIDTH-1], (lo_d == '0), (hi_d != '0), 1'b0};
`ifdef ALU_MC_DIV_EN
    div_tmp  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, opnd_q};
    if (div_q) begin
      if (div_tmp >= {1'b0, opnd_q}) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_tmp[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
      fin_res = lo_d;
      fin_flg = {lo_d[WIDTH-1], (lo_d == '0), (hi_d != '0), 1'b0};
      if (opnd_q == '0) begin
        fin_res = '1;
        fin_flg = 4'b1001;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef ALU_MC_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_iter(bus.op)) begin
              cnt_q  <= CNT_W'(WIDTH);
              hi_q   <= '0;
              opnd_q <= (bus.op == OP_MUL) ? bus.src_a : bus.src_b;
              lo_q   <= (bus.op == OP_MUL) ? bus.src_b : bus.src_a;
`ifdef ALU_MC_DIV_EN
              div_q  <= (bus.op == OP_DIV);
`endif
            end else begin
              {flags_q, result_q} <= alu_basic(bus.op, bus.src_a, bus.src_b);
            end
          end
        end
        ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= fin_res;
            flags_q  <= fin_flg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ITER);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32); honours ALU_MC_DIV_EN for op 110 expectations.
module tb_alu_mc;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got hang required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check, then consume.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [3:0] exp_flg, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'b011;
    bus.src_a    = 32'hDEAD_BEEF;
    bus.src_b    = 32'h1234_5678;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_flg"}, 32'(bus.flags), 32'(exp_flg));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_bad         = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("sub_eq",   3'b001, 32'd5,          32'd5,          32'd0,          4'b0110, 1);
    run_op("sub_ovf",  3'b001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011, 1);
    run_op("add_ovf",  3'b000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001, 1);
    run_op("eor",      3'b100, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  4'b1000, 1);
    run_op("and",      3'b010, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  4'b0000, 1);
    run_op("orr_zero", 3'b011, 32'd0,          32'd0,          32'd0,          4'b0100, 1);
    run_op("illegal",  3'b111, 32'd9,          32'd3,          32'd0,          4'b0101, 1);
    run_op("mul_hi",   3'b101, 32'h0001_0000,  32'h0001_0000,  32'd0,          4'b0110, 33);
    run_op("mul_small",3'b101, 32'd7,          32'd6,          32'd42,         4'b0000, 33);
    run_op("mul_max",  3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          4'b0010, 33);
`ifdef ALU_MC_DIV_EN
    run_op("div",      3'b110, 32'd100,        32'd7,          32'd14,         4'b0010, 33);
    run_op("div_zero", 3'b110, 32'd5,          32'd0,          32'hFFFF_FFFF,  4'b1001, 33);
`else
    run_op("op110",    3'b110, 32'd100,        32'd7,          32'd0,          4'b0101, 1);
`endif

    // Backpressure: ADD completes, consumer stalls while a new request waits.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd4;
    @(posedge clk);
    #1;
    bus.op    = 3'b001;
    bus.src_a = 32'd100;
    bus.src_b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_result", bus.result, 32'd7);
      chk("bp_flags", 32'(bus.flags), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_after_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_after_result", bus.result, 32'd7);

    // Async reset during ITER cycle 5 of a MUL.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'b101;
    bus.src_a    = 32'd7;
    bus.src_b    = 32'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_flags", 32'(bus.flags), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_op("add_post", 3'b000, 32'd10, 32'd20, 32'd30, 4'b0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
